// File: rtl/input_conditioner.sv
// input_conditioner: per-line synchroniser, debouncer and edge detector for buttons/DIP switches.
// Optional feature macro INPUT_COND_STM_EN: when defined, stm_hwevents carries {fall_pulse, rise_pulse};
// when undefined, stm_hwevents is tied to zero and its register is not built.
module input_conditioner #(
    parameter int               WIDTH           = 8,
    parameter int               DEBOUNCE_CYCLES = 50000,
    parameter logic [WIDTH-1:0] INVERT_MASK     = 'h0F
) (
    input  logic             clk,
    input  logic             reset_n,
    input  logic [WIDTH-1:0] raw_in,
    output logic [WIDTH-1:0] stable_out,
    output logic [WIDTH-1:0] rise_pulse,
    output logic [WIDTH-1:0] fall_pulse,
    output logic             any_change,
    output logic [27:0]      stm_hwevents
);
    localparam int             CW       = $clog2(DEBOUNCE_CYCLES + 1);
    localparam logic [CW-1:0]  CNT_LAST = CW'(DEBOUNCE_CYCLES - 1);

    logic [WIDTH-1:0] s1_q, s2_q, l;
    logic [WIDTH-1:0] stable_q, stable_d, rise_q, rise_d, fall_q, fall_d;
    logic [CW-1:0]    cnt_q [WIDTH];
    logic [CW-1:0]    cnt_d [WIDTH];
    logic             any_q;

    assign l          = s2_q ^ INVERT_MASK;
    assign stable_out = stable_q;
    assign rise_pulse = rise_q;
    assign fall_pulse = fall_q;
    assign any_change = any_q;

    // Two-flop synchroniser; resets to the inversion mask so every logical line starts at 0
    always_ff @(posedge clk) begin
        s1_q <= !reset_n ? INVERT_MASK : raw_in;
        s2_q <= !reset_n ? INVERT_MASK : s1_q;
    end

    // Per-bit debounce: any sample matching the accepted level restarts the count
    always_comb begin
        cnt_d    = cnt_q;
        stable_d = stable_q;
        rise_d   = '0;
        fall_d   = '0;
        for (int i = 0; i < WIDTH; i++) begin
            if (l[i] == stable_q[i]) begin
                cnt_d[i] = '0;
            end else if (cnt_q[i] == CNT_LAST) begin
                cnt_d[i]    = '0;
                stable_d[i] = l[i];
                rise_d[i]   = l[i];
                fall_d[i]   = !l[i];
            end else begin
                cnt_d[i] = cnt_q[i] + 1'b1;
            end
        end
    end

    // Debounce state and registered edge events
    always_ff @(posedge clk) begin
        if (!reset_n) begin
            for (int i = 0; i < WIDTH; i++) cnt_q[i] <= '0;
            stable_q <= '0;
            rise_q   <= '0;
            fall_q   <= '0;
            any_q    <= 1'b0;
        end else begin
            cnt_q    <= cnt_d;
            stable_q <= stable_d;
            rise_q   <= rise_d;
            fall_q   <= fall_d;
            any_q    <= |{rise_d, fall_d};
        end
    end

`ifdef INPUT_COND_STM_EN
    logic [27:0] stm_q;

    // Trace event word registered alongside the pulses so it carries no extra latency
    always_ff @(posedge clk) begin
        stm_q <= !reset_n ? 28'h0 : 28'({fall_d, rise_d});
    end

    assign stm_hwevents = stm_q;
`else
    assign stm_hwevents = 28'h0;
`endif
endmodule

// File: tb/tb_input_conditioner.sv
// tb_input_conditioner: scoreboard bench; driver queues expected events, monitor checks them as the DUT pulses.
module tb_input_conditioner;
    logic        clk = 1'b0;
    logic        reset_n = 1'b0;
    logic [7:0]  raw_in = 8'h0F;
    logic [7:0]  stable_out, rise_pulse, fall_pulse;
    logic        any_change;
    logic [27:0] stm_hwevents;

    input_conditioner #(.WIDTH(8), .DEBOUNCE_CYCLES(4), .INVERT_MASK(8'h0F)) dut (
        .clk(clk), .reset_n(reset_n), .raw_in(raw_in), .stable_out(stable_out),
        .rise_pulse(rise_pulse), .fall_pulse(fall_pulse), .any_change(any_change),
        .stm_hwevents(stm_hwevents)
    );

    always #5 clk = ~clk;

    typedef struct {
        int         cyc;
        logic [7:0] rise;
        logic [7:0] fall;
        logic [7:0] stable;
    } exp_t;

    exp_t       q[$];
    int         cyc = 0;
    int         n_cmp = 0;
    int         n_fail = 0;
    logic       rst_q = 1'b0;
    logic [7:0] lvl = 8'h0;
    logic [7:0] exp_stable = 8'h0;

    always @(posedge clk) begin
        cyc   <= cyc + 1;
        rst_q <= reset_n;
    end

    task automatic chk(input string name, input logic [63:0] act, input logic [63:0] exp);
        n_cmp++;
        if (act !== exp) begin
            n_fail++;
            $display("FAIL %s at cycle %0d: got %0h, expected %0h", name, cyc, act, exp);
        end
    endtask

    function automatic logic [27:0] stm_of(input logic [7:0] r, input logic [7:0] f);
`ifdef INPUT_COND_STM_EN
        return {12'h0, f, r};
`else
        return 28'h0;
`endif
    endfunction

    // Monitor: pops one expected event per DUT pulse, otherwise demands silence
    always @(negedge clk) begin
        exp_t e;
        if (!rst_q) begin
            exp_stable = 8'h0;
            chk("reset_outputs", {stable_out, rise_pulse, fall_pulse, any_change, stm_hwevents}, 64'h0);
        end else begin
            if (any_change) begin
                if (q.size() == 0) begin
                    chk("unexpected_pulse", {rise_pulse, fall_pulse}, 16'h0);
                end else begin
                    e = q.pop_front();
                    chk("event_cycle", 64'(cyc), 64'(e.cyc));
                    chk("rise_pulse", rise_pulse, e.rise);
                    chk("fall_pulse", fall_pulse, e.fall);
                    chk("stm_hwevents", stm_hwevents, stm_of(e.rise, e.fall));
                    exp_stable = e.stable;
                end
            end else begin
                chk("quiet", {rise_pulse, fall_pulse, stm_hwevents}, 64'h0);
            end
            chk("stable_out", stable_out, exp_stable);
        end
    end

    task automatic step(input int n);
        repeat (n) @(posedge clk);
        #1;
    endtask

    task automatic expect_ev(input int dly, input logic [7:0] r, input logic [7:0] f);
        lvl = (lvl | r) & ~f;
        q.push_back('{cyc + dly, r, f, lvl});
    endtask

    initial begin
        step(3);
        reset_n = 1'b1;
        step(20);
        raw_in[0] = 1'b0;
        expect_ev(6, 8'h01, 8'h00);
        step(12);
        raw_in[0] = 1'b1;
        expect_ev(6, 8'h00, 8'h01);
        step(12);
        for (int k = 0; k < 10; k++) begin
            raw_in[1] = ~raw_in[1];
            step(2);
        end
        raw_in[1] = 1'b0;
        expect_ev(6, 8'h02, 8'h00);
        step(12);
        raw_in[1] = 1'b1;
        expect_ev(6, 8'h00, 8'h02);
        step(12);
        raw_in[2] = 1'b0;
        step(3);
        raw_in[2] = 1'b1;
        step(12);
        raw_in[2] = 1'b0;
        expect_ev(6, 8'h04, 8'h00);
        step(4);
        raw_in[2] = 1'b1;
        expect_ev(6, 8'h00, 8'h04);
        step(12);
        raw_in[3] = 1'b0;
        step(3);
        reset_n = 1'b0;
        step(1);
        raw_in[3] = 1'b1;
        raw_in[4] = 1'b1;
        lvl = 8'h0;
        step(2);
        reset_n = 1'b1;
        expect_ev(6, 8'h10, 8'h00);
        step(12);
        chk("pending_events", 64'(q.size()), 64'h0);
        $display("*** SUMMARY: %0d compared / %0d mismatched ***", n_cmp, n_fail);
        $finish;
    end
endmodule
